// File: rtl/clint_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : clint_timer                                                   |
// | Purpose  : Core-local interruptor holding mtime, mtimecmp and msip,      |
// |            served over a valid/ready request/response bus; drives the    |
// |            registered timer interrupt request (tint).                    |
// | Options  : CLINT_MSIP_EN - implement the msip register at offset 0x0000. |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module clint_timer #(
  parameter int TICK_DIV = 1,
  parameter int ADDR_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MIE,
  input  logic              MTIE,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [63:0]       req_wdata,
  input  logic [7:0]        req_wstrb,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [63:0]       resp_rdata,
  output logic              resp_err,
  output logic              tint,
  output logic              msip_o
);

  localparam logic [ADDR_W-1:0] c_addr_msip  = ADDR_W'(16'h0000);
  localparam logic [ADDR_W-1:0] c_addr_cmp   = ADDR_W'(16'h4000);
  localparam logic [ADDR_W-1:0] c_addr_time  = ADDR_W'(16'hBFF8);
  localparam logic [15:0]       c_presc_last = 16'(TICK_DIV - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [63:0] r_mtime;
  logic [63:0] r_mtimecmp;
  logic [15:0] r_presc;
  logic [63:0] r_rdata;
  logic        r_err;
  logic        r_tint;
  logic        w_accept;
  logic        w_aligned;
  logic        w_hit_msip;
  logic        w_hit_cmp;
  logic        w_hit_time;
  logic        w_err;
  logic        w_wr_cmp;
  logic        w_wr_time;
  logic        w_tick;
  logic        w_msip_val;
  logic [63:0] w_mask;
  logic [63:0] w_rdata;

  // Request decode: only three aligned offsets are mapped.
  assign w_accept   = (r_state == ST_IDLE) && req_valid;
  assign w_aligned  = (req_addr[2:0] == 3'b000);
  assign w_hit_msip = w_aligned && (req_addr == c_addr_msip);
  assign w_hit_cmp  = w_aligned && (req_addr == c_addr_cmp);
  assign w_hit_time = w_aligned && (req_addr == c_addr_time);
  assign w_err      = !(w_hit_msip || w_hit_cmp || w_hit_time);
  assign w_wr_cmp   = w_accept && req_we && w_hit_cmp;
  assign w_wr_time  = w_accept && req_we && w_hit_time;
  assign w_tick     = (r_presc == c_presc_last);

  // Expand byte strobes into a bit mask for the 64-bit store data.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < 8; i++) begin
      w_mask[i*8 +: 8] = {8{req_wstrb[i]}};
    end
  end

  // Load data mux; values are taken before any same-cycle update.
  always_comb begin
    w_rdata = '0;
    if (w_hit_msip) begin
      w_rdata = {63'b0, w_msip_val};
    end else if (w_hit_cmp) begin
      w_rdata = r_mtimecmp;
    end else if (w_hit_time) begin
      w_rdata = r_mtime;
    end
  end

  // Prescaler and mtime; a store to mtime overrides the tick and realigns the prescaler.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mtime <= '0;
      r_presc <= '0;
    end else if (w_wr_time) begin
      r_mtime <= (r_mtime & ~w_mask) | (req_wdata & w_mask);
      r_presc <= '0;
    end else if (w_tick) begin
      r_mtime <= r_mtime + 64'd1;
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 16'd1;
    end
  end

  // mtimecmp register with byte-masked stores.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mtimecmp <= '1;
    end else if (w_wr_cmp) begin
      r_mtimecmp <= (r_mtimecmp & ~w_mask) | (req_wdata & w_mask);
    end
  end

`ifdef CLINT_MSIP_EN
  logic r_msip;

  // Software interrupt pending bit, written through byte lane 0 only.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_msip <= 1'b0;
    end else if (w_accept && req_we && w_hit_msip && req_wstrb[0]) begin
      r_msip <= req_wdata[0];
    end
  end

  assign w_msip_val = r_msip;
`else
  assign w_msip_val = 1'b0;
`endif

  assign msip_o = w_msip_val;

  // Handshake state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and handshake outputs; the response stays up until taken.
  always_comb begin
    w_state_next = r_state;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Response payload captured at the accept edge and held while in RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_rdata <= (req_we || w_err) ? 64'd0 : w_rdata;
      r_err   <= w_err;
    end
  end

  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

  // Registered timer interrupt from the current register values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tint <= 1'b0;
    end else begin
      r_tint <= MIE && MTIE && (r_mtime >= r_mtimecmp);
    end
  end

  assign tint = r_tint;

endmodule
`default_nettype wire

// File: doc/clint_timer.md
Name: clint_timer

Overview:
- Memory-mapped core-local interruptor. It owns mtime, mtimecmp and msip, and serves loads and stores from the LSU over a valid/ready request/response bus.
- It drives the timer-interrupt request consumed by the CSR file, which returns the MIE (mstatus[3]) and MTIE (mie[7]) gating bits.
- This is the producing end of the tint line and replaces the internal timer stub.

Parameters:
- TICK_DIV, 1: core clocks per mtime increment; legal range 1..65535.
- ADDR_W, 16: width of the byte offset into the CLINT window.

Ports:
- clk  input  1  core clock
- rst  input  1  synchronous active-high reset
- MIE  input  1  mstatus.MIE from the CSR file
- MTIE  input  1  mie.MTIE from the CSR file
- req_valid  input  1  request valid
- req_ready  output  1  block can accept a request
- req_we  input  1  1 = store, 0 = load
- req_addr  input  ADDR_W  byte offset, 8-byte aligned
- req_wdata  input  64  store data
- req_wstrb  input  8  byte enables for stores
- resp_valid  output  1  response valid
- resp_ready  input  1  requester accepts the response
- resp_rdata  output  64  load data; 0 for stores and errors
- resp_err  output  1  unmapped or misaligned access
- tint  output  1  registered timer interrupt request
- msip_o  output  1  software interrupt pending

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-high. Reset values:
  - mtime = 0, mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF, msip = 0, prescaler = 0
  - tint = 0, resp_valid = 0, resp_err = 0, resp_rdata = 0, req_ready = 1, FSM = IDLE
- Address map:
  - 0x0000: msip, bit 0 only
  - 0x4000: mtimecmp
  - 0xBFF8: mtime
  - Any other offset, or req_addr[2:0] != 0, completes with resp_err = 1. A store to such an address has no side effect.
- Prescaler:
  - Counts 0..TICK_DIV-1. mtime += 1 (wraps modulo 2^64) in the cycle the prescaler equals TICK_DIV-1, and the prescaler then returns to 0.
  - With TICK_DIV = 1, mtime increments every cycle.
- Handshake FSM:
  - IDLE: req_ready = 1. On req_valid, the request is accepted: any store is performed this edge and the response is registered. Go to RESP.
  - RESP: req_ready = 0, resp_valid = 1, data and err held stable. On resp_ready, go to IDLE. resp_valid may not drop before the response is accepted.
  - Latency: the response is visible 1 cycle after acceptance. Maximum throughput is 1 request per 2 cycles.
- Loads return the value at the accept edge, before any increment in the same cycle.
- Stores are byte-masked by req_wstrb.
- A store to mtime in the same cycle as a tick: the stored value wins and the tick is dropped. The prescaler is also cleared.
- tint:
  - tint is registered: tint <= MIE & MTIE & (mtime >= mtimecmp), using an unsigned 64-bit compare on the current-cycle register values.
  - Asserts 1 cycle after the condition becomes true. Deasserts 1 cycle after mtimecmp is raised above mtime or MIE/MTIE drop.
  - The CSR file clears MIE on trap entry, so tint falls the cycle after trap entry.
- A reset asserted while in RESP aborts the response: resp_valid = 0 on the next cycle and the pending store is not repeated.

Optional Feature:
- Macro: CLINT_MSIP_EN.
- Defined: msip is implemented and writable via bit 0 at 0x0000, with wstrb[0] gating the write. msip_o = msip and is registered. Load returns {63'b0, msip}.
- Undefined: offset 0x0000 still decodes without error, reads 0 and ignores writes. msip_o is tied 0.

Test Plan:
- Reset, TICK_DIV = 1, no bus traffic for 10 cycles -> tint = 0; a load of 0xBFF8 returns the mtime value at its accept edge.
- MIE = 1, MTIE = 1, store mtimecmp = 20 at cycle 0 -> tint rises exactly 1 cycle after mtime first reads >= 20. Then store mtimecmp = all-ones -> tint = 0 one cycle later.
- TICK_DIV = 4: store mtime = 64'hFFFF_FFFF_FFFF_FFFE, wait 8 cycles -> mtime = 0 (wrap). A store of 0x1234 to mtime coinciding with a tick -> readback = 0x1234 + subsequent ticks only.
- Store to 0x4000 with wstrb = 8'h0F, data = all-ones, after reset -> mtimecmp = all-ones unchanged. Then wstrb = 8'h01, data = 0x05 -> mtimecmp low byte = 0x05, others stay 0xFF.
- Load from 0x0008 and from 0x4004 -> resp_err = 1, resp_rdata = 0, no state change. Hold resp_ready = 0 for 5 cycles -> resp_valid, data and err held, req_ready = 0 throughout.
- With CLINT_MSIP_EN, store 1 to 0x0000 -> msip_o = 1 one cycle after acceptance, readback 1. Without it -> msip_o = 0, readback 0, resp_err = 0.
